shift_reg_seq: RTL and testbench

SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

---
 rtl/shift_reg_seq.sv | 136 +++++++++++++
 tb/tb_shift_reg_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: WIDTH-bit shift register with manual hold/load/shift modes
// and an automatic multi-bit shift sequencer (IDLE -> SHIFT -> DONE).
// Optional build macro: SHIFT_ROTATE_EN -- when defined, the fill bit is the
// bit being shifted out (rotate) and ser_in is ignored; otherwise the fill
// bit is ser_in. The port list is the same in both builds.
// Reset is synchronous and active-low (reset_n).
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;
  logic             r_dir;   // 0 = right, 1 = left
  logic [CNT_W-1:0] r_cnt;   // remaining automatic shifts

  logic             w_fill_r;
  logic             w_fill_l;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

`ifdef SHIFT_ROTATE_EN
  // Rotate: the bit leaving one end re-enters at the other.
  assign w_fill_r = r_q[0];
  assign w_fill_l = r_q[WIDTH-1];
`else
  assign w_fill_r = ser_in;
  assign w_fill_l = ser_in;
`endif

  assign w_shr = {w_fill_r, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], w_fill_l};

  // Sequencer FSM with the register, serial output and status flags all registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && mode[1]) begin
            // Accept: latch direction and count; q is untouched this cycle.
            r_dir  <= mode[0];
            r_cnt  <= count;
            r_busy <= 1'b1;
            if (count == '0) begin
              // Zero-length run: a single busy cycle that is also the done cycle.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end else begin
            case (mode)
              2'b01: r_q <= d;
              2'b10: begin
                r_q   <= w_shr;
                r_ser <= r_q[0];
              end
              2'b11: begin
                r_q   <= w_shl;
                r_ser <= r_q[WIDTH-1];
              end
              default: ;
            endcase
          end
        end

        S_SHIFT: begin
          if (r_cnt != '0) begin
            if (r_dir) begin
              r_q   <= w_shl;
              r_ser <= r_q[WIDTH-1];
            end else begin
              r_q   <= w_shr;
              r_ser <= r_q[0];
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            // Defensive: nothing left to shift, finish immediately.
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q       = r_q;
  assign ser_out = r_ser;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed self-checking bench for shift_reg_seq (WIDTH=8).
// Expected values are hand-computed; rotate-build values are selected with
// SHIFT_ROTATE_EN so the same bench serves both builds.
module tb_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

`ifdef SHIFT_ROTATE_EN
  localparam logic [7:0] EXP_R3_1 = 8'hC0;
  localparam logic [7:0] EXP_R3_2 = 8'h60;
  localparam logic [7:0] EXP_R3_3 = 8'h30;
  localparam logic [7:0] EXP_MID  = 8'h69;
  localparam logic [7:0] EXP_L2   = 8'h00;
  localparam logic [7:0] EXP_LONG = 8'hFF;
  localparam logic [7:0] EXP_ROT8 = 8'h0F;
`else
  localparam logic [7:0] EXP_R3_1 = 8'h40;
  localparam logic [7:0] EXP_R3_2 = 8'h20;
  localparam logic [7:0] EXP_R3_3 = 8'h10;
  localparam logic [7:0] EXP_MID  = 8'h29;
  localparam logic [7:0] EXP_L2   = 8'h03;
  localparam logic [7:0] EXP_LONG = 8'h00;
  localparam logic [7:0] EXP_ROT8 = 8'h00;
`endif

  logic             clk;
  logic             reset_n;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .d       (d),
    .ser_in  (ser_in),
    .start   (start),
    .count   (count),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    int cyc;
    bit seen;
    checks = 0;
    failures = 0;
    reset_n = 1'b0; mode = 2'b00; d = '0; ser_in = 1'b0; start = 1'b0; count = '0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_ser", 32'(ser_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // Load then hold
    mode = 2'b01; d = 8'hA5; tick();
    mode = 2'b00; d = 8'h00; tick(); tick(); tick();
    chk("hold_q", 32'(q), 32'hA5);
    chk("hold_ser", 32'(ser_out), 32'h0);
    chk("hold_busy", 32'(busy), 32'h0);

    // Automatic right shift by 3 from 0x81
    mode = 2'b01; d = 8'h81; tick();
    ser_in = 1'b0; start = 1'b1; mode = 2'b10; count = 4'd3; tick();
    start = 1'b0; mode = 2'b00;
    chk("r3_acc_q", 32'(q), 32'h81);
    chk("r3_acc_busy", 32'(busy), 32'h1);
    chk("r3_acc_done", 32'(done), 32'h0);
    tick();
    chk("r3_s1_q", 32'(q), 32'(EXP_R3_1));
    chk("r3_s1_ser", 32'(ser_out), 32'h1);
    tick();
    chk("r3_s2_q", 32'(q), 32'(EXP_R3_2));
    chk("r3_s2_done", 32'(done), 32'h0);
    tick();
    chk("r3_s3_q", 32'(q), 32'(EXP_R3_3));
    chk("r3_s3_ser", 32'(ser_out), 32'h0);
    chk("r3_s3_busy", 32'(busy), 32'h1);
    chk("r3_s3_done", 32'(done), 32'h1);
    tick();
    chk("r3_end_busy", 32'(busy), 32'h0);
    chk("r3_end_done", 32'(done), 32'h0);
    chk("r3_end_q", 32'(q), 32'(EXP_R3_3));

    // Automatic left shift with count 0
    mode = 2'b01; d = 8'h01; tick();
    ser_in = 1'b1; start = 1'b1; mode = 2'b11; count = 4'd0; tick();
    start = 1'b0; mode = 2'b00;
    chk("c0_q", 32'(q), 32'h01);
    chk("c0_busy", 32'(busy), 32'h1);
    chk("c0_done", 32'(done), 32'h1);
    tick();
    chk("c0_end_busy", 32'(busy), 32'h0);
    chk("c0_end_done", 32'(done), 32'h0);
    chk("c0_end_q", 32'(q), 32'h01);
    chk("c0_ser", 32'(ser_out), 32'h0);

    // Manual left shift one step
    mode = 2'b01; d = 8'h81; tick();
    mode = 2'b11; ser_in = 1'b1; tick();
    mode = 2'b00;
    chk("man_l_q", 32'(q), 32'h03);
    chk("man_l_ser", 32'(ser_out), 32'h1);

    // Inputs disturbed while busy are ignored
    mode = 2'b01; d = 8'h81; tick();
    ser_in = 1'b0; start = 1'b1; mode = 2'b10; count = 4'd3; tick();
    mode = 2'b01; d = 8'hFF; start = 1'b1; count = 4'd7;
    tick();
    chk("dist_s1_q", 32'(q), 32'(EXP_R3_1));
    tick(); tick();
    chk("dist_s3_q", 32'(q), 32'(EXP_R3_3));
    chk("dist_s3_done", 32'(done), 32'h1);
    tick();
    chk("dist_end_busy", 32'(busy), 32'h0);
    chk("dist_end_q", 32'(q), 32'(EXP_R3_3));
    start = 1'b0; mode = 2'b00; d = 8'h00; count = 4'd0;
    tick();
    chk("dist_idle_busy", 32'(busy), 32'h0);
    chk("dist_idle_q", 32'(q), 32'(EXP_R3_3));

    // Reset aborts a run mid-shift
    mode = 2'b01; d = 8'hA5; tick();
    ser_in = 1'b0; start = 1'b1; mode = 2'b10; count = 4'd5; tick();
    start = 1'b0; mode = 2'b00;
    tick(); tick();
    chk("mid_q", 32'(q), 32'(EXP_MID));
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_ser", 32'(ser_out), 32'h0);
    tick();
    chk("abort_idle_done", 32'(done), 32'h0);
    ser_in = 1'b1; start = 1'b1; mode = 2'b11; count = 4'd2; tick();
    start = 1'b0; mode = 2'b00;
    chk("restart_busy", 32'(busy), 32'h1);
    tick(); tick();
    chk("restart_q", 32'(q), 32'(EXP_L2));
    chk("restart_done", 32'(done), 32'h1);
    tick();

    // Count larger than WIDTH: done after count+1 cycles
    mode = 2'b01; d = 8'hFF; tick();
    ser_in = 1'b0; start = 1'b1; mode = 2'b10; count = 4'(WIDTH + 2); tick();
    start = 1'b0; mode = 2'b00;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk("long_seen", 32'(seen), 32'h1);
    chk("long_latency", 32'(cyc), 32'(WIDTH + 3));
    chk("long_q", 32'(q), 32'(EXP_LONG));
    tick();

    // Eight manual right shifts of 0x0F
    mode = 2'b01; d = 8'h0F; tick();
    ser_in = 1'b0; mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("man8_ser%0d", i), 32'(ser_out), (i < 4) ? 32'h1 : 32'h0);
    end
    mode = 2'b00;
    chk("man8_q", 32'(q), 32'(EXP_ROT8));
    chk("man8_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
